// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: round-robin arbiter between L1I and L1D for the single
// shared l1mmu port. One request in flight at a time; the MMU-facing request
// is registered and held stable until mmu_done, then a one-cycle done pulse
// and the captured line are returned to the granted cache.
module l1_mmu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              sys_clk,
  input  logic              rst,
  // L1 instruction cache
  input  logic              i_req_read,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_read_data,
  // L1 data cache
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_read_data,
  // shared l1mmu port
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  // status
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state_q;
  logic              prio_d_q;
  logic              grant_d_q;
  logic              mmu_rd_q;
  logic              mmu_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              i_done_q;
  logic              d_done_q;

  logic i_pend, d_pend, gnt_d_d;

  // Grant decision: a lone requester always wins; a tie goes to prio_d_q.
  always_comb begin
    i_pend  = i_req_read;
    d_pend  = d_req_read | d_req_write;
    gnt_d_d = d_pend & (~i_pend | prio_d_q);
  end

  // Arbiter FSM with all MMU-facing and cache-facing outputs registered.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_d_q  <= 1'b1;
      grant_d_q <= 1'b0;
      mmu_rd_q  <= 1'b0;
      mmu_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      // done strobes are single-cycle by construction
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_pend | d_pend) begin
            grant_d_q <= gnt_d_d;
            // the loser of this grant gets priority on the next tie
            prio_d_q  <= ~gnt_d_d;
            if (gnt_d_d) begin
              // write-back wins over read if a cache ever drives both
              mmu_wr_q <= d_req_write;
              mmu_rd_q <= ~d_req_write;
              addr_q   <= d_req_addr;
              wdata_q  <= d_write_data;
              state_q  <= BUSY_D;
            end else begin
              mmu_wr_q <= 1'b0;
              mmu_rd_q <= 1'b1;
              addr_q   <= i_req_addr;
              wdata_q  <= '0;
              state_q  <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // request registers are frozen; only mmu_done is observed
          if (mmu_done) begin
            rdata_q  <= mmu_read_data;
            mmu_rd_q <= 1'b0;
            mmu_wr_q <= 1'b0;
            i_done_q <= (state_q == BUSY_I);
            d_done_q <= (state_q == BUSY_D);
            state_q  <= DONE;
          end
        end
        DONE: begin
          // requester drops its level request on this edge
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_done         = i_done_q;
  assign d_done         = d_done_q;
  assign i_read_data    = rdata_q;
  assign d_read_data    = rdata_q;
  assign mmu_req_read   = mmu_rd_q;
  assign mmu_req_write  = mmu_wr_q;
  assign mmu_req_addr   = addr_q;
  assign mmu_write_data = wdata_q;
  assign grant_d        = grant_d_q;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Directed vector bench for l1_mmu_arbiter: a per-cycle table of inputs and
// expected registered outputs, plus a hand-written write-hold sequence.
module tb_l1_mmu_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              sys_clk;
  logic              rst;
  logic              i_req_read;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_req_read;
  logic              d_req_write;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic              grant_d;

  l1_mmu_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_req_read(i_req_read), .i_req_addr(i_req_addr),
    .i_done(i_done), .i_read_data(i_read_data),
    .d_req_read(d_req_read), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_write_data(d_write_data),
    .d_done(d_done), .d_read_data(d_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
    .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
    .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .grant_d(grant_d)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string             nm;
    bit                rst;
    bit                ird;
    logic [ADDR_W-1:0] ia;
    bit                drd;
    bit                dwr;
    logic [ADDR_W-1:0] da;
    logic [LINE_W-1:0] dw;
    bit                md;
    logic [LINE_W-1:0] mdt;
    bit                erd;
    bit                ewr;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ew;
    bit                eid;
    bit                edd;
    bit                egd;
    logic [LINE_W-1:0] er;
  } vec_t;

  vec_t vecs[64];
  int   nv;
  int   n_chk;
  int   n_pass;

  logic [LINE_W-1:0] ZL, A5, B, C, W, NW, DD, E, F, G, H, R6, W2, XD;

  task automatic v(input string nm, input bit rs, input bit ird, input logic [ADDR_W-1:0] ia,
                   input bit drd, input bit dwr, input logic [ADDR_W-1:0] da,
                   input logic [LINE_W-1:0] dw, input bit md, input logic [LINE_W-1:0] mdt,
                   input bit erd, input bit ewr, input logic [ADDR_W-1:0] ea,
                   input logic [LINE_W-1:0] ew, input bit eid, input bit edd, input bit egd,
                   input logic [LINE_W-1:0] er);
    vecs[nv] = '{nm, rs, ird, ia, drd, dwr, da, dw, md, mdt, erd, ewr, ea, ew, eid, edd, egd, er};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  initial begin
    logic [ADDR_W-1:0] ia, da;
    logic [LINE_W-1:0] md, prev;
    bit gd;
    int pulses, ipulses;

    n_chk = 0; n_pass = 0; nv = 0;
    rst = 1'b1; i_req_read = 0; i_req_addr = '0; d_req_read = 0; d_req_write = 0;
    d_req_addr = '0; d_write_data = '0; mmu_done = 0; mmu_read_data = '0;

    ZL = '0;           A5 = {32{8'hA5}};      B  = {8{32'hDEADBEEF}};
    C  = {16{16'h0F0F}}; W = {16{16'h1234}};  NW = ~W;
    DD = {8{32'h0000FFFF}}; E = {32{8'h3C}};  F  = {8{32'hF00DF00D}};
    G  = {8{32'h11112222}}; H = {8{32'h76543210}};
    W2 = {8{32'hCAFEF00D}}; XD = {8{32'h5A5A0001}};

    // reset and an uncontested I read
    v("rst",        1,0,0,     0,0,0,     ZL,0,ZL, 0,0,0,     ZL,0,0,0,ZL);
    v("idle",       0,0,0,     0,0,0,     ZL,0,ZL, 0,0,0,     ZL,0,0,0,ZL);
    v("i_grant",    0,1,'h40,  0,0,0,     ZL,0,ZL, 1,0,'h40,  ZL,0,0,0,ZL);
    v("i_busy1",    0,1,'h40,  0,0,0,     ZL,0,ZL, 1,0,'h40,  ZL,0,0,0,ZL);
    v("i_busy2",    0,1,'h40,  0,0,0,     ZL,0,ZL, 1,0,'h40,  ZL,0,0,0,ZL);
    v("i_mdone",    0,1,'h40,  0,0,0,     ZL,1,A5, 0,0,'h40,  ZL,1,0,0,A5);
    v("i_idle",     0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'h40,  ZL,0,0,0,A5);
    // both requesting out of reset: D first, then I at u+3
    v("rst_both",   1,1,'h200, 1,0,'h100, ZL,0,ZL, 0,0,0,     ZL,0,0,0,ZL);
    v("tie_d",      0,1,'h200, 1,0,'h100, ZL,0,ZL, 1,0,'h100, ZL,0,0,1,ZL);
    v("d_busy",     0,1,'h200, 1,0,'h100, ZL,0,ZL, 1,0,'h100, ZL,0,0,1,ZL);
    v("d_mdone",    0,1,'h200, 1,0,'h100, ZL,1,B,  0,0,'h100, ZL,0,1,1,B);
    v("d_done_iw",  0,1,'h200, 0,0,0,     ZL,0,ZL, 0,0,'h100, ZL,0,0,1,B);
    v("i_second",   0,1,'h200, 0,0,0,     ZL,0,ZL, 1,0,'h200, ZL,0,0,0,B);
    v("i_mdone2",   0,1,'h200, 0,0,0,     ZL,1,C,  0,0,'h200, ZL,1,0,0,C);
    v("i_idle2",    0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'h200, ZL,0,0,0,C);
    // D write-back, inputs change during BUSY
    v("dwr_grant",  0,0,0,     0,1,'h300, W, 0,ZL, 0,1,'h300, W, 0,0,1,C);
    v("dwr_chg",    0,1,0,     0,1,'h304, NW,0,ZL, 0,1,'h300, W, 0,0,1,C);
    v("dwr_mdone",  0,1,0,     0,1,'h304, NW,1,DD, 0,0,'h300, W, 0,1,1,DD);
    v("dwr_done",   0,1,'h400, 0,0,0,     ZL,0,ZL, 0,0,'h300, W, 0,0,1,DD);
    v("i3_grant",   0,1,'h400, 0,0,0,     ZL,0,ZL, 1,0,'h400, ZL,0,0,0,DD);
    v("i3_mdone",   0,1,'h400, 0,0,0,     ZL,1,E,  0,0,'h400, ZL,1,0,0,E);
    v("i3_idle",    0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'h400, ZL,0,0,0,E);
    // continuous requests from both: D,I,D,I,D,I
    prev = E;
    for (int t = 0; t < 6; t++) begin
      gd = (t % 2 == 0);
      ia = 32'h600 + 32'(t) * 32'h40;
      da = 32'h500 + 32'(t) * 32'h40;
      md = {8{32'(t + 1)}};
      v($sformatf("rr%0d_g", t), 0,1,ia,1,0,da,ZL,0,ZL, 1,0,gd ? da : ia,ZL,0,0,gd,prev);
      v($sformatf("rr%0d_m", t), 0,1,ia,1,0,da,ZL,1,md, 0,0,gd ? da : ia,ZL,!gd,gd,gd,md);
      v($sformatf("rr%0d_d", t), 0,1,ia,1,0,da,ZL,0,ZL, 0,0,gd ? da : ia,ZL,0,0,gd,md);
      prev = md;
    end
    R6 = prev;
    // spurious mmu_done in IDLE
    v("spur",       0,0,0,     0,0,0,     ZL,1,F,  0,0,'h740, ZL,0,0,0,R6);
    v("spur_idle",  0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'h740, ZL,0,0,0,R6);
    // reset in BUSY_D, then I-only, then a tie that goes to D
    v("rd_grant",   0,0,0,     1,0,'h700, ZL,0,ZL, 1,0,'h700, ZL,0,0,1,R6);
    v("rd_busy",    0,0,0,     1,0,'h700, ZL,0,ZL, 1,0,'h700, ZL,0,0,1,R6);
    v("rst_busy",   1,0,0,     1,0,'h700, ZL,1,F,  0,0,0,     ZL,0,0,0,ZL);
    v("post_i",     0,1,'h800, 0,0,0,     ZL,0,ZL, 1,0,'h800, ZL,0,0,0,ZL);
    v("post_i_md",  0,1,'h800, 0,0,0,     ZL,1,G,  0,0,'h800, ZL,1,0,0,G);
    v("post_i_idl", 0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'h800, ZL,0,0,0,G);
    v("tie2",       0,1,'h900, 1,0,'hA00, ZL,0,ZL, 1,0,'hA00, ZL,0,0,1,G);
    v("tie2_md",    0,1,'h900, 1,0,'hA00, ZL,1,H,  0,0,'hA00, ZL,0,1,1,H);
    v("tie2_idle",  0,0,0,     0,0,0,     ZL,0,ZL, 0,0,'hA00, ZL,0,0,1,H);

    for (int k = 0; k < nv; k++) begin
      @(negedge sys_clk);
      rst = vecs[k].rst; i_req_read = vecs[k].ird; i_req_addr = vecs[k].ia;
      d_req_read = vecs[k].drd; d_req_write = vecs[k].dwr; d_req_addr = vecs[k].da;
      d_write_data = vecs[k].dw; mmu_done = vecs[k].md; mmu_read_data = vecs[k].mdt;
      @(posedge sys_clk); #1;
      chk({vecs[k].nm, ".rd"},    mmu_req_read,   vecs[k].erd);
      chk({vecs[k].nm, ".wr"},    mmu_req_write,  vecs[k].ewr);
      chk({vecs[k].nm, ".addr"},  mmu_req_addr,   vecs[k].ea);
      chk({vecs[k].nm, ".wdata"}, mmu_write_data, vecs[k].ew);
      chk({vecs[k].nm, ".idone"}, i_done,         vecs[k].eid);
      chk({vecs[k].nm, ".ddone"}, d_done,         vecs[k].edd);
      chk({vecs[k].nm, ".gd"},    grant_d,        vecs[k].egd);
      chk({vecs[k].nm, ".irdat"}, i_read_data,    vecs[k].er);
      chk({vecs[k].nm, ".drdat"}, d_read_data,    vecs[k].er);
    end

    // hand sequence: long write-back with inputs churning while BUSY_D
    @(negedge sys_clk);
    rst = 0; i_req_read = 0; d_req_read = 0; d_req_write = 1;
    d_req_addr = 32'hB00; d_write_data = W2; mmu_done = 0;
    @(posedge sys_clk); #1;
    chk("hs_grant.wr", mmu_req_write, 1'b1);
    chk("hs_grant.rd", mmu_req_read, 1'b0);
    chk("hs_grant.gd", grant_d, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      d_write_data = {8{$urandom}};
      d_req_addr = $urandom;
      i_req_read = 1;
      @(posedge sys_clk); #1;
      chk($sformatf("hs_hold%0d.wdata", i), mmu_write_data, W2);
      chk($sformatf("hs_hold%0d.addr", i), mmu_req_addr, 32'hB00);
      chk($sformatf("hs_hold%0d.wr", i), mmu_req_write, 1'b1);
    end
    @(negedge sys_clk);
    mmu_done = 1; mmu_read_data = XD;
    @(posedge sys_clk); #1;
    chk("hs_done.ddone", d_done, 1'b1);
    chk("hs_done.idone", i_done, 1'b0);
    chk("hs_done.data", d_read_data, XD);
    chk("hs_done.wr", mmu_req_write, 1'b0);
    @(negedge sys_clk);
    mmu_done = 0; d_req_write = 0; i_req_read = 0;
    pulses = 0; ipulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk); #1;
      pulses += int'(d_done);
      ipulses += int'(i_done);
    end
    chk("hs_after.dpulses", 256'(pulses), 256'(0));
    chk("hs_after.ipulses", 256'(ipulses), 256'(0));
    chk("hs_after.data", i_read_data, XD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l1_mmu_arbiter.md
# l1_mmu_arbiter

Two-port arbiter between the L1 instruction cache, the L1 data cache and the single shared `l1mmu` port. It accepts cache-line requests from both caches, grants one at a time with round-robin priority, and presents a registered, stable request to the MMU. It holds that request until the MMU completes, then returns a one-cycle done pulse and the line data to the granted cache. It replaces the ad-hoc combinational MMU steering logic in the top level.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `LINE_W`, 256, cache line width

Ports:
- `sys_clk`  in  1  system clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `i_req_read`  in  1  L1I line read request, level, held until `i_done`
- `i_req_addr`  in  ADDR_W  L1I line address
- `i_done`  out  1  one-cycle completion pulse to L1I
- `i_read_data`  out  LINE_W  line data to L1I
- `d_req_read`  in  1  L1D line read request, level, held until `d_done`
- `d_req_write`  in  1  L1D line write-back request, level, held until `d_done`
- `d_req_addr`  in  ADDR_W  L1D line address
- `d_write_data`  in  LINE_W  L1D write-back line
- `d_done`  out  1  one-cycle completion pulse to L1D
- `d_read_data`  out  LINE_W  line data to L1D
- `mmu_req_read`  out  1  read request to l1mmu
- `mmu_req_write`  out  1  write request to l1mmu
- `mmu_req_addr`  out  ADDR_W  address to l1mmu
- `mmu_write_data`  out  LINE_W  write line to l1mmu
- `mmu_done`  in  1  l1mmu completion pulse
- `mmu_read_data`  in  LINE_W  l1mmu read line, valid with `mmu_done`
- `grant_d`  out  1  status: 1 while the current/last grant belongs to L1D

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - `i_pend = i_req_read`; `d_pend = d_req_read | d_req_write`.
  - Only one pending: grant it.
  - Both pending: grant D if `prio_d = 1`, else I.
  - On grant, latch addr, write data, read/write type and requester into output registers, then go to BUSY_I or BUSY_D.
  - `prio_d` is 0 after any D grant and 1 after any I grant. Uncontested grants update it too.
- D type: if `d_req_write` is set, the request is a write and `d_req_read` is ignored (both high is illegal). Otherwise it is a read. L1I is always a read.
- BUSY_x:
  - `mmu_req_read`/`mmu_req_write`, `mmu_req_addr` and `mmu_write_data` are held constant.
  - Input changes are ignored.
  - On `mmu_done`: capture `mmu_read_data` into the shared data register, deassert the MMU request, go to DONE.
- DONE: pulse `i_done` or `d_done` for the granted requester for exactly one cycle, then go to IDLE. The requester drops its request on this edge, so IDLE never re-grants a completed request.
- `i_read_data` and `d_read_data` are both driven from the shared data register. It is captured on every `mmu_done`, writes included, and holds until the next capture.
- `mmu_done` in IDLE or DONE is ignored.

## Timing
- Reset: state IDLE and `prio_d = 1`. All outputs are 0, including the data registers, `grant_d` and the MMU request/address/data.
- Request sampled in IDLE at edge t → MMU request high from t+1.
- `mmu_done` at cycle u → at u+1 the MMU request is low, `x_done = 1` and data is valid. At u+2 the state is IDLE.
- Minimum turnaround: a new request sampled at u+2 has its MMU request high at u+3. Back-to-back grants therefore cost 2 idle MMU cycles.
- `mmu_done` in the same cycle as the grant edge cannot occur, because the MMU request is not yet visible.
- `rst` asserted mid-transaction: immediate return to IDLE and outputs zeroed, with no done pulse. The in-flight MMU access is abandoned; l1mmu is reset on the same edge.
- Starvation bound: with both caches requesting continuously, grants strictly alternate D, I, D, I…

## Test plan
- Reset, then `i_req_read = 1` with addr 0x0000_0040. Expect `mmu_req_read = 1`, addr 0x40 and `grant_d = 0` next cycle. Return `mmu_done` with data 0xA5…A5 three cycles later. Expect `i_done` for 1 cycle with `i_read_data` = 0xA5…A5 and `d_done = 0`.
- Both requesting at reset: D read at 0x100, I read at 0x200. Expect D granted first, then I at u+3. Each done goes only to its owner.
- D write at 0x300 with data 0x1234…. Expect `mmu_req_write = 1`, `mmu_req_read = 0` and stable data. Change `d_write_data` during BUSY; `mmu_write_data` must be unchanged.
- Continuous requests from both for 6 transactions. Expect grant order D,I,D,I,D,I and exactly one done pulse per transaction.
- Spurious `mmu_done` in IDLE. Expect no done pulse and no state change.
- Assert `rst` while in BUSY_D. Expect all outputs 0 next cycle and no `d_done`. The following I-only request is granted normally, and a subsequent tie goes to D.
